// File: rtl/prog_mem_if.sv
// Fetch and byte-stream load bus for prog_mem.
// Latency: n/a (signal bundle only).
// Backpressure: oLoadReady gates iLoadValid; fetch side has no backpressure.
interface prog_mem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0] iAddress;
  logic                  iReadEnable;
  logic [DATA_WIDTH-1:0] oInstruction;
  logic                  oValid;
  logic                  iLoadStart;
  logic [ADDR_WIDTH:0]   iLoadLength;
  logic [7:0]            iLoadData;
  logic                  iLoadValid;
  logic                  oLoadReady;
  logic                  oBusy;
  logic                  oLoadDone;
  logic                  oLoadError;

  modport master (
    output iAddress, iReadEnable, iLoadStart, iLoadLength, iLoadData, iLoadValid,
    input  oInstruction, oValid, oLoadReady, oBusy, oLoadDone, oLoadError
  );

  modport slave (
    input  iAddress, iReadEnable, iLoadStart, iLoadLength, iLoadData, iLoadValid,
    output oInstruction, oValid, oLoadReady, oBusy, oLoadDone, oLoadError
  );
endinterface

// File: rtl/prog_mem.sv
// Program memory loaded MSB-first from a byte stream, fetched by address.
// Latency: fetch data and oValid one cycle after iReadEnable; oLoadDone one cycle after the last word write.
// Backpressure: bytes accepted only while oLoadReady (LOAD state); fetches ignored during LOAD.
module prog_mem #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DEPTH        = 256,
  parameter int                    DATA_WIDTH   = 28,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
  input logic       Clock,
  input logic       Reset,
  prog_mem_if.slave bus
);

  localparam int BYTES_PER_WORD = (DATA_WIDTH + 7) / 8;
  localparam int ACC_WIDTH      = BYTES_PER_WORD * 8;
  localparam int BCNT_WIDTH     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ADDR_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [BCNT_WIDTH-1:0] BCNT_ONE  = BCNT_WIDTH'(1);
  localparam logic [BCNT_WIDTH-1:0] LAST_BYTE = BCNT_WIDTH'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        word_vld;
  logic [ADDR_WIDTH:0]     word_addr;
  logic [ADDR_WIDTH:0]     load_len;
  logic                    len_err;
  logic [BCNT_WIDTH-1:0]   byte_cnt;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic                    byte_take;
  logic                    word_wr;
  logic                    rd_hit;

  // Byte acceptance, word assembly and read-hit decode.
  always_comb begin
    byte_take = bus.iLoadValid && bus.oLoadReady;
    acc_next  = ACC_WIDTH'({acc, bus.iLoadData});
    word_wr   = byte_take && (byte_cnt == LAST_BYTE) && (word_addr < load_len);
    rd_hit    = 1'b0;
    if ({1'b0, bus.iAddress} < DEPTH_L) begin
      rd_hit = word_vld[bus.iAddress];
    end
  end

  // Instruction storage; deliberately not reset, the valid bits gate reads.
  always_ff @(posedge Clock) begin
    if (word_wr) begin
      mem[word_addr[ADDR_WIDTH-1:0]] <= acc_next[DATA_WIDTH-1:0];
    end
  end

  // Load FSM, per-word valid bits and registered fetch port.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state            <= IDLE;
      word_vld         <= '0;
      word_addr        <= '0;
      load_len         <= '0;
      len_err          <= 1'b0;
      byte_cnt         <= '0;
      acc              <= '0;
      bus.oInstruction <= '0;
      bus.oValid       <= 1'b0;
      bus.oBusy        <= 1'b0;
      bus.oLoadReady   <= 1'b0;
      bus.oLoadDone    <= 1'b0;
      bus.oLoadError   <= 1'b0;
    end else begin
      if (bus.iReadEnable && (state != LOAD)) begin
        bus.oValid       <= 1'b1;
        bus.oInstruction <= rd_hit ? mem[bus.iAddress] : DEFAULT_WORD;
      end else begin
        bus.oValid       <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.iLoadStart) begin
            word_vld       <= '0;
            word_addr      <= '0;
            byte_cnt       <= '0;
            acc            <= '0;
            load_len       <= (bus.iLoadLength > DEPTH_L) ? DEPTH_L : bus.iLoadLength;
            len_err        <= (bus.iLoadLength > DEPTH_L);
            state          <= LOAD;
            bus.oBusy      <= 1'b1;
            bus.oLoadReady <= 1'b1;
          end
        end
        LOAD: begin
          if (load_len == '0) begin
            state          <= DONE;
            bus.oBusy      <= 1'b0;
            bus.oLoadReady <= 1'b0;
            bus.oLoadDone  <= 1'b1;
            bus.oLoadError <= len_err;
          end else if (byte_take) begin
            acc <= acc_next;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              word_vld[word_addr[ADDR_WIDTH-1:0]] <= 1'b1;
              word_addr <= word_addr + ADDR_ONE;
              if ((word_addr + ADDR_ONE) == load_len) begin
                state          <= DONE;
                bus.oBusy      <= 1'b0;
                bus.oLoadReady <= 1'b0;
                bus.oLoadDone  <= 1'b1;
                bus.oLoadError <= len_err;
              end
            end else begin
              byte_cnt <= byte_cnt + BCNT_ONE;
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.oLoadDone  <= 1'b0;
          bus.oLoadError <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: directed loads and fetches, scoreboarded outputs.
// Latency: expects fetch data one cycle after request, done one cycle after last byte.
// Backpressure: byte sender waits (bounded) on oLoadReady.
module tb_prog_mem;
  localparam int              AW  = 8;
  localparam int              DW  = 28;
  localparam logic [DW-1:0]   DEF = 28'h5EED123;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  prog_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_mem #(
    .ADDR_WIDTH(AW), .DEPTH(256), .DATA_WIDTH(DW), .DEFAULT_WORD(DEF)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] fetch_q [$];
  logic          done_q  [$];
  logic [7:0]    prog_a  [8] = '{8'h0A, 8'hBC, 8'hDE, 8'hF1, 8'h01, 8'h23, 8'h45, 8'h67};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expected values whenever the DUT presents fetch data or a done pulse.
  always @(negedge Clock) begin
    if (Reset) begin
      if (bus.oValid) begin
        if (fetch_q.size() == 0) fail_now("unexpected_fetch_valid");
        else check("fetch_data", 32'(bus.oInstruction), 32'(fetch_q.pop_front()));
      end
      if (bus.oLoadDone) begin
        if (done_q.size() == 0) fail_now("unexpected_load_done");
        else check("load_error_flag", 32'(bus.oLoadError), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus.iAddress    = a;
    bus.iReadEnable = 1'b1;
    fetch_q.push_back(e);
    tick();
    bus.iReadEnable = 1'b0;
  endtask

  task automatic start(input logic [AW:0] len, input logic expect_done, input logic exp_err);
    bus.iLoadStart  = 1'b1;
    bus.iLoadLength = len;
    if (expect_done) done_q.push_back(exp_err);
    tick();
    bus.iLoadStart  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.iLoadValid = 1'b1;
    bus.iLoadData  = b;
    while (!bus.oLoadReady && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) fail_now("load_ready_timeout");
    tick();
    bus.iLoadValid = 1'b0;
  endtask

  task automatic finish_load(input logic exp_err);
    check("done_after_last_byte", 32'(bus.oLoadDone), 32'd1);
    check("done_error_direct", 32'(bus.oLoadError), 32'(exp_err));
    check("busy_in_done", 32'(bus.oBusy), 32'd0);
    tick();
    check("done_single_pulse", 32'(bus.oLoadDone), 32'd0);
  endtask

  task automatic load_prog_a();
    start(9'd2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(prog_a[i]);
    finish_load(1'b0);
  endtask

  initial begin
    bus.iAddress    = '0;
    bus.iReadEnable = 1'b0;
    bus.iLoadStart  = 1'b0;
    bus.iLoadLength = '0;
    bus.iLoadData   = '0;
    bus.iLoadValid  = 1'b0;
    #2;
    check("rst_valid", 32'(bus.oValid), 32'd0);
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    check("rst_ready", 32'(bus.oLoadReady), 32'd0);
    check("rst_done", 32'(bus.oLoadDone), 32'd0);
    check("rst_instr", 32'(bus.oInstruction), 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    tick();

    // Fetch on an empty memory.
    fetch(8'd5, DEF);
    check("busy_idle", 32'(bus.oBusy), 32'd0);
    tick();
    check("valid_drops", 32'(bus.oValid), 32'd0);

    // Plain two-word load.
    load_prog_a();
    fetch(8'd0, 28'hABCDEF1);
    fetch(8'd1, 28'h1234567);
    fetch(8'd2, DEF);

    // Same load with gaps and an ignored start pulse mid-load.
    start(9'd2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog_a[i]);
      if (i == 3) begin
        bus.iLoadStart  = 1'b1;
        bus.iLoadLength = 9'd5;
        tick();
        bus.iLoadStart  = 1'b0;
        tick();
        check("busy_mid_load", 32'(bus.oBusy), 32'd1);
      end else if (i < 7) begin
        tick();
        tick();
      end
    end
    finish_load(1'b0);
    fetch(8'd0, 28'hABCDEF1);
    fetch(8'd1, 28'h1234567);
    fetch(8'd2, DEF);

    // Reset in the middle of a load.
    start(9'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(prog_a[i]);
    Reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.oBusy), 32'd0);
    check("abort_ready", 32'(bus.oLoadReady), 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    fetch(8'd0, DEF);
    fetch(8'd1, DEF);

    // Length zero after a real load clears the valid bits.
    load_prog_a();
    fetch(8'd0, 28'hABCDEF1);
    start(9'd0, 1'b1, 1'b0);
    check("len0_busy", 32'(bus.oBusy), 32'd1);
    check("len0_no_done_yet", 32'(bus.oLoadDone), 32'd0);
    tick();
    check("len0_done", 32'(bus.oLoadDone), 32'd1);
    check("len0_error", 32'(bus.oLoadError), 32'd0);
    tick();
    fetch(8'd0, DEF);
    fetch(8'd1, DEF);

    // Oversized length is clamped to DEPTH.
    begin
      int accepted = 0;
      start(9'd300, 1'b1, 1'b1);
      for (int w = 0; w < 256; w++) begin
        logic [7:0] v;
        v = 8'(w);
        send_byte(8'hF0);
        send_byte(v);
        send_byte(~v);
        send_byte(v ^ 8'h3C);
        accepted += 4;
      end
      check("clamp_bytes", 32'(accepted), 32'd1024);
      finish_load(1'b1);
    end
    fetch(8'd255, 28'h0FF00C3);
    fetch(8'd0,   28'h000FF3C);
    fetch(8'd128, 28'h0807FBC);

    tick();
    tick();
    tick();
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: fetch/write address width.
REQ-002 Parameter DEPTH, default 256: number of instruction words, at most 2^ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 28: instruction word width.
REQ-004 Parameter DEFAULT_WORD, default 0: word returned for unloaded or out-of-range addresses.
REQ-005 Derived constant BYTES_PER_WORD SHALL equal ceil(DATA_WIDTH/8), which is 4 at defaults.
REQ-006 The design SHALL use a single clock; reset is asynchronous and active-low.
REQ-007 Clock  in  1  system clock, rising edge.
REQ-008 Reset  in  1  asynchronous, active-low reset.
REQ-009 iAddress  in  ADDR_WIDTH  fetch address.
REQ-010 iReadEnable  in  1  fetch request.
REQ-011 oInstruction  out  DATA_WIDTH  registered fetch data.
REQ-012 oValid  out  1  oInstruction updated by the previous cycle's fetch.
REQ-013 iLoadStart  in  1  single-cycle pulse that begins a program load.
REQ-014 iLoadLength  in  ADDR_WIDTH+1  word count, sampled with iLoadStart.
REQ-015 iLoadData  in  8  load byte.
REQ-016 iLoadValid  in  1  iLoadData present.
REQ-017 oLoadReady  out  1  load byte accepted this cycle if iLoadValid is high.
REQ-018 oBusy  out  1  load in progress.
REQ-019 oLoadDone  out  1  single-cycle pulse at load completion.
REQ-020 oLoadError  out  1  single-cycle pulse together with oLoadDone when the length was clamped.

Function
REQ-021 State machine SHALL have three states: IDLE, LOAD, DONE.
- IDLE -> LOAD on iLoadStart.
- LOAD -> DONE when the last word is written.
- DONE -> IDLE unconditionally after one cycle.
REQ-022 On iLoadStart in IDLE, the block SHALL:
- clear all per-word valid bits;
- reset word address and byte counter to 0;
- latch the length as min(iLoadLength, DEPTH).
REQ-023 If iLoadLength > DEPTH, oLoadError SHALL pulse in the DONE cycle.
REQ-024 iLoadLength = 0 SHALL go IDLE -> LOAD -> DONE with no write.
REQ-025 iLoadStart outside IDLE SHALL be ignored.
REQ-026 oLoadReady and oBusy SHALL be high exactly in LOAD; oLoadDone SHALL be high exactly in DONE.
REQ-027 Byte assembly:
- a byte is accepted when iLoadValid and oLoadReady are both high;
- the first byte of a word is the most significant;
- the word is the low DATA_WIDTH bits of the BYTES_PER_WORD*8-bit assembly; excess high bits are discarded.
REQ-028 On acceptance of the BYTES_PER_WORD-th byte, the block SHALL, on that clock edge:
- write the word to memory at the current word address;
- set that word's valid bit;
- increment the word address.
REQ-029 The cycle after the final word write SHALL be DONE.
REQ-030 Gaps in iLoadValid SHALL stall assembly without data loss.
REQ-031 Fetch:
- iReadEnable in IDLE or DONE at cycle t SHALL give oInstruction and oValid=1 at t+1;
- oInstruction = memory word if iAddress < DEPTH and its valid bit is set, else DEFAULT_WORD.
REQ-032 No fetch cycle (iReadEnable low, or state LOAD) SHALL give oValid=0 next cycle, with oInstruction holding its value.
REQ-033 Memory array contents SHALL not be reset; the valid bits alone gate reads.

Reset
REQ-034 Reset low SHALL asynchronously force:
- state IDLE;
- all valid bits, counters, oInstruction, oValid, oBusy, oLoadReady, oLoadDone and oLoadError to 0.
REQ-035 Reset asserted mid-load SHALL abort the load; no partial word is written.
REQ-036 The block SHALL resume normal operation on the first rising edge of Clock after Reset deasserts.

Verification
REQ-037 Reset then fetch of address 5 -> next cycle oInstruction=DEFAULT_WORD, oValid=1; oBusy=0.
REQ-038 Load length 2 with bytes 0A BC DE F1 01 23 45 67, then fetch addresses 0, 1, 2 ->
- oLoadDone pulses once, one cycle after the 8th byte is accepted;
- fetch results 28'hABCDEF1, 28'h1234567, DEFAULT_WORD.
REQ-039 Load length 2 with idle gaps between bytes, plus an iLoadStart pulse during LOAD -> same memory contents as REQ-038; the second start is ignored.
REQ-040 Reset low after 5 bytes of a length-2 load, then fetch address 0 -> DEFAULT_WORD; oBusy=0.
REQ-041 Length 0 -> oLoadDone two cycles after iLoadStart, oLoadError=0, all prior words read DEFAULT_WORD.
REQ-042 Length 300 with DEPTH=256 -> 1024 bytes accepted, then oLoadDone and oLoadError pulse together; fetch of address 255 returns the last word.
